// File: rtl/udp_tx.sv
// UDP transmit framer: prepends an 8-byte UDP header (src, dst, length, zero checksum)
// to a byte-wide payload frame, holding the payload in a short delay line meanwhile.
module udp_tx #(
  parameter logic [15:0] P_SOURCE_PORT = 16'h8080,
  parameter logic [15:0] P_TARGET_PORT = 16'h8080
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_target_port,
  input  logic        i_target_port_valid,
  input  logic [15:0] i_source_port,
  input  logic        i_source_port_valid,
  input  logic [7:0]  i_udp_data,
  input  logic [15:0] i_udp_len,
  input  logic        i_udp_last,
  input  logic        i_udp_valid,
  output logic        o_udp_ready,
  output logic [7:0]  o_ip_data,
  output logic [15:0] o_ip_len,
  output logic        o_ip_last,
  output logic        o_ip_valid
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Eight pipe stages plus the output register give the 9-cycle payload delay.
  localparam int DLY = 8;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [7:0]  hdr_src_lo_q, hdr_src_lo_d;
  logic [15:0] hdr_dst_q, hdr_dst_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic        ready_q, ready_d;
  logic        in_q, in_d;
  logic        drop_q, drop_d;

  logic        start;
  logic        accept;
  logic [7:0]  hdr_byte;

  logic [7:0]  pipe_data_q  [DLY];
  logic [7:0]  pipe_data_d  [DLY];
  logic        pipe_valid_q [DLY];
  logic        pipe_valid_d [DLY];
  logic        pipe_last_q  [DLY];
  logic        pipe_last_d  [DLY];

  logic        tail_valid;
  logic        tail_last;
  logic [7:0]  tail_data;

  assign tail_valid = pipe_valid_q[DLY-1];
  assign tail_last  = pipe_last_q[DLY-1];
  assign tail_data  = pipe_data_q[DLY-1];

  // A frame only starts on a byte that is not already part of an accepted or dropped frame.
  assign start  = i_udp_valid && (state_q == ST_IDLE) && ready_q && !in_q && !drop_q;
  assign accept = i_udp_valid && (start || in_q);

  genvar gi;
  generate
    for (gi = 0; gi < DLY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_valid_d[gi] = accept;
        assign pipe_last_d[gi]  = accept && i_udp_last;
        assign pipe_data_d[gi]  = i_udp_data;
      end else begin : g_tail
        assign pipe_valid_d[gi] = pipe_valid_q[gi-1];
        assign pipe_last_d[gi]  = pipe_last_q[gi-1];
        assign pipe_data_d[gi]  = pipe_data_q[gi-1];
      end
    end
  endgenerate

  // Header byte that goes out next while cnt_q indexes the byte currently on the output.
  always_comb begin
    case (cnt_q)
      3'd0:    hdr_byte = hdr_src_lo_q;
      3'd1:    hdr_byte = hdr_dst_q[15:8];
      3'd2:    hdr_byte = hdr_dst_q[7:0];
      3'd3:    hdr_byte = len_q[15:8];
      3'd4:    hdr_byte = len_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    src_d        = i_source_port_valid ? i_source_port : src_q;
    dst_d        = i_target_port_valid ? i_target_port : dst_q;
    hdr_src_lo_d = hdr_src_lo_q;
    hdr_dst_d    = hdr_dst_q;
    len_d        = len_q;
    data_d       = data_q;
    last_d       = last_q;
    valid_d      = valid_q;
    ready_d      = ready_q;
    in_d         = in_q;
    drop_d       = drop_q;

    if (start) begin
      in_d = !i_udp_last;
    end else if (in_q && i_udp_valid && i_udp_last) begin
      in_d = 1'b0;
    end

    if (i_udp_valid && !start && !in_q && !drop_q) begin
      drop_d = !i_udp_last;
    end else if (drop_q && i_udp_valid && i_udp_last) begin
      drop_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (start) begin
          state_d      = ST_HEAD;
          cnt_d        = 3'd0;
          hdr_src_lo_d = src_q[7:0];
          hdr_dst_d    = dst_q;
          len_d        = i_udp_len + 16'd8;
          ready_d      = 1'b0;
          valid_d      = 1'b1;
          data_d       = src_q[15:8];
        end
      end
      ST_HEAD: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_DATA;
          valid_d = tail_valid;
          last_d  = tail_valid && tail_last;
          if (tail_valid) begin
            data_d = tail_data;
          end
        end else begin
          valid_d = 1'b1;
          last_d  = 1'b0;
          data_d  = hdr_byte;
        end
      end
      ST_DATA: begin
        if (last_q) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          valid_d = tail_valid;
          last_d  = tail_valid && tail_last;
          if (tail_valid) begin
            data_d = tail_data;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      src_q        <= P_SOURCE_PORT;
      dst_q        <= P_TARGET_PORT;
      hdr_src_lo_q <= 8'h00;
      hdr_dst_q    <= 16'h0000;
      len_q        <= 16'h0000;
      data_q       <= 8'h00;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
      ready_q      <= 1'b1;
      in_q         <= 1'b0;
      drop_q       <= 1'b0;
      for (int i = 0; i < DLY; i++) begin
        pipe_data_q[i]  <= 8'h00;
        pipe_valid_q[i] <= 1'b0;
        pipe_last_q[i]  <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      hdr_src_lo_q <= hdr_src_lo_d;
      hdr_dst_q    <= hdr_dst_d;
      len_q        <= len_d;
      data_q       <= data_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      in_q         <= in_d;
      drop_q       <= drop_d;
      for (int i = 0; i < DLY; i++) begin
        pipe_data_q[i]  <= pipe_data_d[i];
        pipe_valid_q[i] <= pipe_valid_d[i];
        pipe_last_q[i]  <= pipe_last_d[i];
      end
    end
  end

  assign o_udp_ready = ready_q;
  assign o_ip_data   = data_q;
  assign o_ip_len    = len_q;
  assign o_ip_last   = last_q;
  assign o_ip_valid  = valid_q;

endmodule

// File: tb/tb_udp_tx.sv
// Scoreboard bench for udp_tx: stimulus pushes the expected datagram bytes with their
// expected output cycle; a negedge monitor pops and compares every valid output byte.
module tb_udp_tx;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [15:0] i_target_port = 16'h0000;
  logic        i_target_port_valid = 1'b0;
  logic [15:0] i_source_port = 16'h0000;
  logic        i_source_port_valid = 1'b0;
  logic [7:0]  i_udp_data = 8'h00;
  logic [15:0] i_udp_len = 16'h0000;
  logic        i_udp_last = 1'b0;
  logic        i_udp_valid = 1'b0;
  logic        o_udp_ready;
  logic [7:0]  o_ip_data;
  logic [15:0] o_ip_len;
  logic        o_ip_last;
  logic        o_ip_valid;

  udp_tx #(
    .P_SOURCE_PORT(16'h8080),
    .P_TARGET_PORT(16'h8080)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_target_port      (i_target_port),
    .i_target_port_valid(i_target_port_valid),
    .i_source_port      (i_source_port),
    .i_source_port_valid(i_source_port_valid),
    .i_udp_data         (i_udp_data),
    .i_udp_len          (i_udp_len),
    .i_udp_last         (i_udp_last),
    .i_udp_valid        (i_udp_valid),
    .o_udp_ready        (o_udp_ready),
    .o_ip_data          (o_ip_data),
    .o_ip_len           (o_ip_len),
    .o_ip_last          (o_ip_last),
    .o_ip_valid         (o_ip_valid)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic [15:0] len;
    int          t;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_src = 16'h8080;
  logic [15:0] m_dst = 16'h8080;
  int          next_free = 0;
  logic [7:0]  fixed_pay [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: every valid output byte must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (o_ip_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte at cycle %0d: actual=%02h required=no output", cyc, o_ip_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_ip_data !== mon_e.d || o_ip_last !== mon_e.l || o_ip_len !== mon_e.len || cyc != mon_e.t) begin
          errors++;
          $display("FAIL out_byte: actual data=%02h last=%0b len=%0d cycle=%0d required data=%02h last=%0b len=%0d cycle=%0d",
                   o_ip_data, o_ip_last, o_ip_len, cyc, mon_e.d, mon_e.l, mon_e.len, mon_e.t);
        end
      end
    end else begin
      chk("last_without_valid", {31'd0, o_ip_last}, 32'd0);
    end
  end

  task automatic clear_inputs();
    i_udp_valid = 1'b0;
    i_udp_last = 1'b0;
    i_target_port_valid = 1'b0;
    i_source_port_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit rnd_ports);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
      clear_inputs();
      chk("ready_idle", {31'd0, o_udp_ready}, {31'd0, cyc >= next_free});
      if (rnd_ports && $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          i_source_port = 16'($urandom);
          i_source_port_valid = 1'b1;
          m_src = i_source_port;
        end else begin
          i_target_port = 16'($urandom);
          i_target_port_valid = 1'b1;
          m_dst = i_target_port;
        end
      end
    end
  endtask

  task automatic load_ports(input logic [15:0] s, input logic [15:0] d);
    @(posedge i_clk); #1;
    clear_inputs();
    chk("ready_idle", {31'd0, o_udp_ready}, {31'd0, cyc >= next_free});
    i_source_port = s;
    i_source_port_valid = 1'b1;
    i_target_port = d;
    i_target_port_valid = 1'b1;
    m_src = s;
    m_dst = d;
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
      clear_inputs();
      i_rst = 1'b0;
      chk("rst_valid", {31'd0, o_ip_valid}, 32'd0);
      chk("rst_ready", {31'd0, o_udp_ready}, 32'd1);
      chk("rst_data", {24'd0, o_ip_data}, 32'd0);
      chk("rst_len", {16'd0, o_ip_len}, 32'd0);
    end
    i_rst = 1'b1;
  endtask

  // Drives one frame; the model decides acceptance from its own busy-until cycle.
  task automatic send_frame(input int len, input bit fixed, input int chg_at,
                            input logic [15:0] chg_val, input int abort_at);
    bit          acc;
    int          t0;
    logic [15:0] lenp8;
    logic [7:0]  b;
    logic [7:0]  hb [8];
    exp_t        e;
    @(posedge i_clk); #1;
    clear_inputs();
    t0 = cyc;
    acc = (cyc >= next_free);
    chk("ready_at_start", {31'd0, o_udp_ready}, {31'd0, acc});
    lenp8 = 16'(len + 8);
    if (acc) begin
      hb[0] = m_src[15:8]; hb[1] = m_src[7:0];
      hb[2] = m_dst[15:8]; hb[3] = m_dst[7:0];
      hb[4] = lenp8[15:8]; hb[5] = lenp8[7:0];
      hb[6] = 8'h00;       hb[7] = 8'h00;
      for (int i = 0; i < 8; i++) begin
        e.d = hb[i]; e.l = 1'b0; e.len = lenp8; e.t = t0 + 1 + i;
        exp_q.push_back(e);
      end
      next_free = t0 + len + 9;
    end
    $display("frame t=%0d len=%0d src=%04h dst=%04h %s", t0, len, m_src, m_dst, acc ? "accepted" : "dropped");
    for (int k = 0; k < len; k++) begin
      if (k > 0) begin
        @(posedge i_clk); #1;
        clear_inputs();
      end
      if (k == abort_at) begin
        i_rst = 1'b0;
        exp_q.delete();
        next_free = 0;
        m_src = 16'h8080;
        m_dst = 16'h8080;
        #1;
        chk("valid_after_abort", {31'd0, o_ip_valid}, 32'd0);
        chk("ready_after_abort", {31'd0, o_udp_ready}, 32'd1);
        return;
      end
      b = fixed ? fixed_pay[k] : 8'($urandom);
      i_udp_valid = 1'b1;
      i_udp_data = b;
      i_udp_last = (k == len - 1);
      i_udp_len = 16'(len);
      if (k == chg_at) begin
        i_target_port = chg_val;
        i_target_port_valid = 1'b1;
        m_dst = chg_val;
      end
      if (acc) begin
        e.d = b; e.l = (k == len - 1); e.len = lenp8; e.t = t0 + 9 + k;
        exp_q.push_back(e);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int chg;
    #2 i_rst = 1'b1;
    #1 i_rst = 1'b0;
    hold_reset(3);
    idle(2, 0);

    // Default ports header
    send_frame(4, 0, -1, 16'h0000, -1);
    idle(14, 0);

    // Basic frame with loaded ports
    load_ports(16'h1234, 16'h5678);
    fixed_pay[0] = 8'hAA; fixed_pay[1] = 8'hBB; fixed_pay[2] = 8'hCC; fixed_pay[3] = 8'hDD;
    send_frame(4, 1, -1, 16'h0000, -1);
    idle(14, 0);

    // Single-byte frame
    fixed_pay[0] = 8'h5A;
    send_frame(1, 1, -1, 16'h0000, -1);
    idle(12, 0);

    // Destination change mid-frame only affects the next frame
    send_frame(6, 0, 3, 16'hBEEF, -1);
    idle(16, 0);
    send_frame(4, 0, -1, 16'h0000, -1);
    idle(14, 0);

    // Busy drop, then a frame exactly at the first ready cycle
    send_frame(4, 0, -1, 16'h0000, -1);
    idle(1, 0);
    send_frame(3, 0, -1, 16'h0000, -1);
    idle(next_free - cyc - 1, 0);
    send_frame(3, 0, -1, 16'h0000, -1);
    idle(14, 0);

    // Reset in the middle of a long frame
    send_frame(20, 0, -1, 16'h0000, 10);
    hold_reset(3);
    idle(8, 0);

    // Randomised frames, gaps and port updates
    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(1, 24);
      chg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      send_frame(len, 0, chg, 16'($urandom), -1);
      idle($urandom_range(0, 12), 1);
    end

    idle(24, 0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
